spi_tx_arbiter: RTL and testbench

SPI-slave transmit arbiter for the FPGA application slot. It shares the single MISO shift-out path between four on-chip data requesters. A host transaction carries an 8-bit command that selects a fixed requester or asks for round-robin service. The block grants one requester, consumes its word through a valid/ready handshake, and shifts a flag bit plus the word out MSB-first, replacing the hard-wired counter source.

---
 rtl/spi_tx_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_spi_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
//
// Transmit arbiter for the SPI-slave MISO path. A host transaction starts on
// an SSEL falling edge. The block returns an 8-bit status byte ({4'b0000,
// req_valid}) while it receives an 8-bit command. It then grants one of four
// requesters and shifts a flag bit followed by the granted word out on MISO,
// MSB first.
//
// Command byte:
//   cmd[7] = 1 : fixed channel, cmd[1:0] selects the requester.
//   cmd[7] = 0 : round-robin, starting after last_ch.
//   cmd[6:2]   : ignored.
//
// Ports:
//   clk, rst_n  system clock; asynchronous active-low reset
//   SSEL        SPI chip select, active low, asynchronous to clk
//   SCK         SPI clock, mode 0 (host samples on rise, block drives on fall)
//   MOSI        SPI host data
//   MISO        SPI slave data; high-Z outside a transaction
//   req_valid   per-requester "word available"
//   req_data    requester n word at [n*WIDTH +: WIDTH]
//   req_ready   one-clk pulse when requester n's word is consumed
//   busy        high whenever the FSM is not IDLE
//   last_ch     most recently granted requester
//
// Requester handshake: a word moves on the clk edge where req_valid[n] and
// req_ready[n] are both high. req_ready is driven only in the GRANT cycle.
// A requester must hold req_valid high and req_data stable until it sees
// req_ready. The block never waits on req_valid: if the chosen channel is not
// valid in GRANT, the transaction carries flag 0 and a zero word.
module spi_tx_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SSEL,
  input  logic               SCK,
  input  logic               MOSI,
  inout  wire                MISO,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic               busy,
  output logic [1:0]         last_ch
);

  // The counter covers 8 command bits and WIDTH+2 shift-phase falls.
  localparam int CW = ($clog2(WIDTH + 2) > 3) ? $clog2(WIDTH + 2) : 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    GRANT = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Per pin: [0] and [1] form the synchronizer, [2] is the edge-detect flop.
  logic [2:0] ssel_s;
  logic [2:0] sck_s;
  logic [2:0] mosi_s;

  logic ssel_fall;
  logic ssel_rise;
  logic sck_rise;
  logic sck_fall;

  logic [CW-1:0] cnt_q;
  logic [7:0]    cmd_q;
  logic [6:0]    status_q;   // status[6:0]; status[7] is always 0
  logic [WIDTH:0] sh_q;      // {flag, word}
  logic          miso_q;
  logic          miso_oe;

  logic [1:0] sel_ch;
  logic       sel_hit;
  logic [1:0] cand;
  logic       grant_fire;

  // The SSEL chain resets low. If SSEL is still low when reset is released,
  // no false falling edge is seen, and the block stays idle until a real
  // SSEL fall arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_s <= 3'b000;
      sck_s  <= 3'b000;
      mosi_s <= 3'b000;
    end else begin
      ssel_s <= {ssel_s[1:0], SSEL};
      sck_s  <= {sck_s[1:0], SCK};
      mosi_s <= {mosi_s[1:0], MOSI};
    end
  end

  assign ssel_fall = ~ssel_s[1] &  ssel_s[2];
  assign ssel_rise =  ssel_s[1] & ~ssel_s[2];
  assign sck_rise  =  sck_s[1]  & ~sck_s[2];
  assign sck_fall  = ~sck_s[1]  &  sck_s[2];

  // Channel selection. It is evaluated every cycle, but it is used only in
  // GRANT.
  always_comb begin
    sel_ch  = cmd_q[1:0];
    sel_hit = 1'b0;
    cand    = 2'b00;
    if (cmd_q[7]) begin
      sel_hit = req_valid[cmd_q[1:0]];
    end else begin
      for (int i = 1; i <= 4; i++) begin
        cand = last_ch + 2'(i);
        if (!sel_hit && req_valid[cand]) begin
          sel_hit = 1'b1;
          sel_ch  = cand;
        end
      end
    end
  end

  // An SSEL rise in the GRANT cycle aborts the grant, so no word is lost.
  assign grant_fire = (state == GRANT) && sel_hit && !ssel_rise;
  assign req_ready  = grant_fire ? (4'b0001 << sel_ch) : 4'b0000;
  assign busy       = (state != IDLE);
  assign MISO       = miso_oe ? miso_q : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ssel_fall) state_next = CMD;
      CMD:     if (sck_rise && cnt_q == CW'(7)) state_next = GRANT;
      GRANT:   state_next = SHIFT;
      SHIFT:   if (sck_fall && cnt_q == CW'(WIDTH + 1)) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (ssel_rise) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      cmd_q    <= '0;
      status_q <= '0;
      sh_q     <= '0;
      miso_q   <= 1'b0;
      miso_oe  <= 1'b0;
      last_ch  <= 2'b11;
    end else if (ssel_rise) begin
      miso_oe <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ssel_fall) begin
            status_q <= {3'b000, req_valid};
            cnt_q    <= '0;
            miso_oe  <= 1'b1;
            miso_q   <= 1'b0;   // status[7]
          end
        end
        CMD: begin
          if (sck_rise) begin
            // mosi_s[2] is aligned with the pre-edge SCK sample. MOSI is
            // stable across the whole SCK high/low phase in mode 0.
            cmd_q <= {cmd_q[6:0], mosi_s[2]};
            cnt_q <= cnt_q + CW'(1);
          end
          if (sck_fall) begin
            miso_q   <= status_q[6];
            status_q <= {status_q[5:0], 1'b0};
          end
        end
        GRANT: begin
          cnt_q <= '0;
          if (sel_hit) begin
            sh_q    <= {1'b1, req_data[int'(sel_ch) * WIDTH +: WIDTH]};
            last_ch <= sel_ch;
          end else begin
            sh_q <= '0;
          end
        end
        SHIFT: begin
          // Falls 0..WIDTH of this phase drive the flag and then the word.
          // The next fall drives 0 and enters DONE.
          if (sck_fall) begin
            if (cnt_q == CW'(WIDTH + 1)) begin
              miso_q <= 1'b0;
            end else begin
              miso_q <= sh_q[WIDTH];
              sh_q   <= {sh_q[WIDTH-1:0], 1'b0};
              cnt_q  <= cnt_q + CW'(1);
            end
          end
        end
        DONE:    miso_q <= 1'b0;
        default: miso_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Testbench for spi_tx_arbiter: directed vector table, hand-written corner
// sequences (abort, reset mid-shift) and random transactions checked against
// a rule-level reference model. MISO has a pull-up, so a released line
// reads 1.
module tb_spi_tx_arbiter;

  localparam int W = 16;
  localparam int H = 6;   // SCK half period in clk cycles

  logic           clk;
  logic           rst_n;
  logic           ssel;
  logic           sck;
  logic           mosi;
  wire            miso;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_data;
  logic [3:0]     req_ready;
  logic           busy;
  logic [1:0]     last_ch;

  pullup (miso);

  int checks = 0;
  int errors = 0;
  int m_last = 3;
  logic [3:0] exp_q[$];

  spi_tx_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SSEL      (ssel),
    .SCK       (sck),
    .MOSI      (mosi),
    .MISO      (miso),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .busy      (busy),
    .last_ch   (last_ch)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: req_ready pulses ----------------
  always @(negedge clk) begin
    if (rst_n && req_ready != 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready actual=%b required=0000", req_ready);
      end else begin
        check("ready_pulse", 64'(req_ready), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ssel_low();
    @(negedge clk);
    ssel = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic sck_bit(input logic mosi_bit, output logic miso_bit);
    mosi = mosi_bit;
    repeat (H) @(negedge clk);
    miso_bit = miso;
    sck = 1'b1;
    repeat (H) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic ssel_high();
    repeat (H) @(negedge clk);
    ssel = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_xfer(input logic [7:0] c, input int n, output logic [63:0] rx);
    logic b;
    rx = '0;
    ssel_low();
    for (int i = 0; i < n; i++) begin
      sck_bit((i < 8) ? c[7-i] : 1'b0, b);
      rx = {rx[62:0], b};
    end
    ssel_high();
  endtask

  // Bits the host expects to read: status byte, flag, word, then zeros.
  function automatic logic [63:0] build_stream(input logic [7:0] st, input logic fl,
                                               input logic [W-1:0] wd, input int n);
    logic [63:0] s;
    logic [8+W:0] full;
    logic bitv;
    full = {st, fl, wd};
    s = '0;
    for (int i = 0; i < n; i++) begin
      bitv = 1'b0;
      if (i <= 8 + W) bitv = full[8+W-i];
      s = {s[62:0], bitv};
    end
    return s;
  endfunction

  // Reference model: apply the arbitration rules to the command.
  task automatic model_xfer(input string name, input logic [7:0] c, input logic [3:0] v,
                            input logic [4*W-1:0] d, input int n);
    int ch;
    logic [63:0] rx;
    logic fl;
    logic [W-1:0] wd;
    ch = -1;
    if (c[7]) begin
      if (v[c[1:0]]) ch = int'(c[1:0]);
    end else begin
      for (int k = 1; k <= 4; k++)
        if (ch < 0 && v[(m_last + k) % 4]) ch = (m_last + k) % 4;
    end
    fl = (ch >= 0);
    wd = fl ? d[ch*W +: W] : '0;
    if (fl) begin
      exp_q.push_back(4'b0001 << ch);
      m_last = ch;
    end
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    run_xfer(c, n, rx);
    check({name, "_stream"}, rx, build_stream({4'b0000, v}, fl, wd, n));
    check({name, "_last_ch"}, 64'(last_ch), 64'(m_last));
    check({name, "_ready_done"}, 64'(exp_q.size()), 64'd0);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]     cmd;
    logic [3:0]     valid;
    logic [4*W-1:0] data;
    int             nbits;
    logic [7:0]     exp_status;
    logic           exp_flag;
    logic [W-1:0]   exp_word;
    logic [3:0]     exp_ready;
    logic [1:0]     exp_last;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [4*W-1:0] dd;
    logic [4*W-1:0] da;
    logic [63:0] rx;
    logic b;

    dd = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    da = {16'h4444, 16'hA5C3, 16'h2222, 16'h1111};
    vecs[0] = '{8'h81, 4'b0101, dd, 25, 8'h05, 1'b0, 16'h0000, 4'b0000, 2'd3};
    vecs[1] = '{8'h00, 4'b1111, dd, 25, 8'h0F, 1'b1, 16'h1111, 4'b0001, 2'd0};
    vecs[2] = '{8'h00, 4'b1111, dd, 25, 8'h0F, 1'b1, 16'h2222, 4'b0010, 2'd1};
    vecs[3] = '{8'h00, 4'b1111, dd, 25, 8'h0F, 1'b1, 16'h3333, 4'b0100, 2'd2};
    vecs[4] = '{8'h00, 4'b1111, dd, 25, 8'h0F, 1'b1, 16'h4444, 4'b1000, 2'd3};
    vecs[5] = '{8'h00, 4'b1111, dd, 25, 8'h0F, 1'b1, 16'h1111, 4'b0001, 2'd0};
    vecs[6] = '{8'h81, 4'b0010, dd, 25, 8'h02, 1'b1, 16'h2222, 4'b0010, 2'd1};
    vecs[7] = '{8'h00, 4'b0001, dd, 25, 8'h01, 1'b1, 16'h1111, 4'b0001, 2'd0};
    vecs[8] = '{8'h82, 4'b0100, da, 28, 8'h04, 1'b1, 16'hA5C3, 4'b0100, 2'd2};

    rst_n = 1'b0; ssel = 1'b1; sck = 1'b0; mosi = 1'b0;
    req_valid = 4'b0000; req_data = '0;
    repeat (4) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);
    check("reset_last_ch", 64'(last_ch), 64'd3);
    check("reset_miso_z", 64'(miso), 64'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      if (vecs[i].exp_ready != 4'b0000) exp_q.push_back(vecs[i].exp_ready);
      run_xfer(vecs[i].cmd, vecs[i].nbits, rx);
      check($sformatf("vec%0d_stream", i), rx,
            build_stream(vecs[i].exp_status, vecs[i].exp_flag, vecs[i].exp_word, vecs[i].nbits));
      check($sformatf("vec%0d_last_ch", i), 64'(last_ch), 64'(vecs[i].exp_last));
      check($sformatf("vec%0d_ready_done", i), 64'(exp_q.size()), 64'd0);
      check($sformatf("vec%0d_miso_z", i), 64'(miso), 64'd1);
    end
    m_last = 2;

    // Abort after 4 command bits; the status is all zero, so MISO drives 0.
    @(negedge clk);
    req_valid = 4'b0000;
    ssel = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("abort_busy_pre", 64'(busy), 64'd0);
    @(posedge clk);
    #1 check("abort_busy_rise", 64'(busy), 64'd1);
    check("abort_miso_status7", 64'(miso), 64'd0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) sck_bit(1'b1, b);
    @(negedge clk);
    ssel = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("abort_busy_hold", 64'(busy), 64'd1);
    check("abort_miso_driven", 64'(miso), 64'd0);
    @(posedge clk);
    #1 check("abort_busy_fall", 64'(busy), 64'd0);
    check("abort_miso_z", 64'(miso), 64'd1);
    repeat (8) @(negedge clk);
    check("abort_last_ch", 64'(last_ch), 64'd2);
    model_xfer("after_abort", 8'h00, 4'b1001, dd, 25);

    // Reset during SHIFT. The grant already happened before the reset.
    req_valid = 4'b0010;
    req_data  = dd;
    exp_q.push_back(4'b0010);
    ssel_low();
    for (int i = 0; i < 12; i++) sck_bit((i < 8) ? ((8'h81 >> (7 - i)) & 1'b1) : 1'b0, b);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_miso_z", 64'(miso), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_last_ch", 64'(last_ch), 64'd3);
    check("rst_ready_seen", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = 3;
    for (int i = 0; i < 4; i++) begin
      sck_bit(1'b0, b);
      check("post_rst_miso_z", 64'(b), 64'd1);
      check("post_rst_busy", 64'(busy), 64'd0);
    end
    ssel_high();
    model_xfer("after_reset", 8'h00, 4'b0110, dd, 25);

    // Random transactions against the model.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] c;
      logic [3:0] v;
      logic [4*W-1:0] d;
      c = 8'($urandom_range(0, 255));
      v = 4'($urandom_range(0, 15));
      d = {$urandom, $urandom};
      model_xfer($sformatf("rand%0d", i), c, v, d, 9 + W + $urandom_range(0, 2));
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
